// File: rtl/valu_issue_sched_if.sv
// valu_issue_sched_if: requester, ALU and writeback signals of the vector ALU issue scheduler.
//   master: the scheduler (drives grants, ALU issue fields, writeback head, error flags)
//   slave : the surroundings (requesters, ALU, writeback consumer)
interface valu_issue_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 128
);
    localparam int TAG_W = $clog2(NUM_REQ);
    logic [NUM_REQ-1:0]        req_valid, req_ready;
    logic [NUM_REQ*47-1:0]     req_op;
    logic [NUM_REQ*DATA_W-1:0] req_src_a, req_src_b;
    logic                      alu_ready, alu_valid;
    logic [5:0]                alu_funct6;
    logic [2:0]                alu_funct3;
    logic [4:0]                alu_rd;
    logic                      alu_dest_is_scalar;
    logic [31:0]               alu_scalar_mask;
    logic [DATA_W-1:0]         alu_src_a, alu_src_b;
    logic                      alu_wb_valid, alu_wb_is_scalar, alu_wb_err_ovf, alu_wb_err_inv;
    logic [4:0]                alu_wb_rd;
    logic [DATA_W-1:0]         alu_wb_data;
    logic                      wb_valid, wb_ready, wb_is_scalar;
    logic [TAG_W-1:0]          wb_tag;
    logic [4:0]                wb_rd;
    logic [DATA_W-1:0]         wb_data;
    logic [1:0]                wb_err;
    logic [2*NUM_REQ-1:0]      err_sticky;
    logic [NUM_REQ-1:0]        err_clr;
    logic                      proto_err;
    modport master (
        input  req_valid, req_op, req_src_a, req_src_b, alu_ready,
               alu_wb_valid, alu_wb_rd, alu_wb_is_scalar, alu_wb_data, alu_wb_err_ovf, alu_wb_err_inv,
               wb_ready, err_clr,
        output req_ready, alu_valid, alu_funct6, alu_funct3, alu_rd, alu_dest_is_scalar, alu_scalar_mask,
               alu_src_a, alu_src_b, wb_valid, wb_tag, wb_rd, wb_is_scalar, wb_data, wb_err,
               err_sticky, proto_err
    );
    modport slave (
        output req_valid, req_op, req_src_a, req_src_b, alu_ready,
               alu_wb_valid, alu_wb_rd, alu_wb_is_scalar, alu_wb_data, alu_wb_err_ovf, alu_wb_err_inv,
               wb_ready, err_clr,
        input  req_ready, alu_valid, alu_funct6, alu_funct3, alu_rd, alu_dest_is_scalar, alu_scalar_mask,
               alu_src_a, alu_src_b, wb_valid, wb_tag, wb_rd, wb_is_scalar, wb_data, wb_err,
               err_sticky, proto_err
    );
endinterface

// File: rtl/valu_issue_sched.sv
// valu_issue_sched: credit-based round-robin issue of NUM_REQ requesters onto one vector ALU,
//   with a tag pipe tracking ops through the ALU and a FWFT tagged writeback FIFO.
//   Ports: clk, rst_n (synchronous, active-low), bus (valu_issue_sched_if.master) carrying
//   requester handshakes, muxed ALU issue fields, ALU results, writeback head and error flags.
module valu_issue_sched #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = 128,
    parameter int ALU_LAT    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input logic clk,
    input logic rst_n,
    valu_issue_sched_if.master bus
);
    localparam int TAG_W = $clog2(NUM_REQ);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int EW    = TAG_W + 5 + 1 + 2 + DATA_W;
    logic [46:0]              ops [NUM_REQ];
    logic [DATA_W-1:0]        srca [NUM_REQ];
    logic [DATA_W-1:0]        srcb [NUM_REQ];
    logic [NUM_REQ-1:0]       rot;
    logic [TAG_W-1:0]         rr_ptr, grant, out_tag;
    logic                     found, issue, credit_ok, out_v, push, pop, proto;
    logic [ALU_LAT-1:0]       pipe_v;
    logic [ALU_LAT*TAG_W-1:0] pipe_tag;
    logic [EW-1:0]            mem [FIFO_DEPTH];
    logic [AW-1:0]            wr_ptr, rd_ptr;
    logic [AW:0]              fifo_cnt;
    logic [2*NUM_REQ-1:0]     sticky;
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign ops[k]  = bus.req_op[k*47 +: 47];
        assign srca[k] = bus.req_src_a[k*DATA_W +: DATA_W];
        assign srcb[k] = bus.req_src_b[k*DATA_W +: DATA_W];
    end
    // Rotate so bit 0 is the requester at rr_ptr; the first set bit is the grant.
    assign rot = NUM_REQ'({bus.req_valid, bus.req_valid} >> rr_ptr);
    always_comb begin
        grant = rr_ptr;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                grant = TAG_W'((int'(rr_ptr) + i) % NUM_REQ);
            end
        end
    end
    // Every op in flight owns a FIFO slot, so a result can always be pushed.
    assign credit_ok = int'(fifo_cnt) + $countones(pipe_v) < FIFO_DEPTH;
    assign issue     = rst_n & found & credit_ok & bus.alu_ready;
    assign bus.req_ready = issue ? NUM_REQ'(1) << grant : '0;
    assign bus.alu_valid = issue;
    assign {bus.alu_funct6, bus.alu_funct3, bus.alu_rd, bus.alu_dest_is_scalar, bus.alu_scalar_mask} =
        issue ? ops[grant] : '0;
    assign bus.alu_src_a = issue ? srca[grant] : '0;
    assign bus.alu_src_b = issue ? srcb[grant] : '0;
    // Oldest tag pipe stage lines up with the ALU result of the same op.
    assign out_v   = pipe_v[ALU_LAT-1];
    assign out_tag = pipe_tag[(ALU_LAT-1)*TAG_W +: TAG_W];
    assign push    = out_v & bus.alu_wb_valid;
    assign pop     = bus.wb_valid & bus.wb_ready;
    assign bus.wb_valid = fifo_cnt != '0;
    assign {bus.wb_tag, bus.wb_rd, bus.wb_is_scalar, bus.wb_err, bus.wb_data} = mem[rd_ptr];
    assign bus.err_sticky = sticky;
    assign bus.proto_err  = proto;
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {out_tag, bus.alu_wb_rd, bus.alu_wb_is_scalar,
                            bus.alu_wb_err_ovf, bus.alu_wb_err_inv, bus.alu_wb_data};
        pipe_tag <= (ALU_LAT*TAG_W)'({pipe_tag, grant});
        if (!rst_n) begin
            pipe_v   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            rr_ptr   <= '0;
            sticky   <= '0;
            proto    <= 1'b0;
        end else begin
            pipe_v   <= ALU_LAT'({pipe_v, issue});
            wr_ptr   <= wr_ptr + AW'(push);
            rd_ptr   <= rd_ptr + AW'(pop);
            fifo_cnt <= fifo_cnt + (AW+1)'(push) - (AW+1)'(pop);
            rr_ptr   <= issue ? TAG_W'((int'(grant) + 1) % NUM_REQ) : rr_ptr;
            proto    <= proto | (out_v ^ bus.alu_wb_valid);
            // A new error for requester i overrides a same-cycle clear.
            for (int i = 0; i < NUM_REQ; i++)
                sticky[2*i +: 2] <= (bus.err_clr[i] ? 2'b00 : sticky[2*i +: 2]) |
                                    (push && out_tag == TAG_W'(i) ? {bus.alu_wb_err_ovf, bus.alu_wb_err_inv} : 2'b00);
        end
    end
endmodule

// File: tb/tb_valu_issue_sched.sv
// tb_valu_issue_sched: directed + randomised bench with a queue-based reference model for valu_issue_sched.
module tb_valu_issue_sched;
    localparam int NR = 4, DW = 128, LAT = 1, FD = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    valu_issue_sched_if #(.NUM_REQ(NR), .DATA_W(DW)) bus();
    valu_issue_sched #(.NUM_REQ(NR), .DATA_W(DW), .ALU_LAT(LAT), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
    typedef struct { int tag; logic [4:0] rd; logic is_s; logic [1:0] err; logic [DW-1:0] data; } ent_t;
    typedef struct { int tag; int due; } infl_t;
    ent_t m_fifo[$];
    infl_t m_pipe[$];
    int m_rr, cyc, checks, errors;
    logic [2*NR-1:0] m_sticky;
    logic m_proto;
    bit chk_en, inject;
    int cnt [NR];
    logic [1:0] req_err [NR];
    int grants[$], pop_tags[$];

    task automatic check(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [46:0] op_word(int k);
        return {req_err[k], 4'(cnt[k]), 3'(k), 5'(cnt[k]*4 + k), 1'(cnt[k]), 8'(k), 24'(cnt[k])};
    endfunction
    function automatic logic [DW-1:0] src_a_of(int k);
        return {32'(k), 32'(cnt[k]), 32'hdeadbeef, 32'(k*7 + cnt[k])};
    endfunction
    function automatic logic [DW-1:0] src_b_of(int k);
        return {32'(cnt[k]*3), 32'hcafef00d, 32'(k), 32'(cnt[k] + 100)};
    endfunction

    task automatic drive_reqs();
        for (int k = 0; k < NR; k++) begin
            bus.req_op[k*47 +: 47]    = op_word(k);
            bus.req_src_a[k*DW +: DW] = src_a_of(k);
            bus.req_src_b[k*DW +: DW] = src_b_of(k);
        end
    endtask

    // One clock: requesters advance on handshake, the bench ALU returns each op one cycle later
    // with data a^b and error flags taken from funct6[5:4].
    task automatic tick();
        logic iss, dis;
        logic [4:0] rd;
        logic [5:0] f6;
        logic [DW-1:0] d;
        logic [NR-1:0] hs;
        @(negedge clk);
        iss = bus.alu_valid;
        rd  = bus.alu_rd;
        dis = bus.alu_dest_is_scalar;
        f6  = bus.alu_funct6;
        d   = bus.alu_src_a ^ bus.alu_src_b;
        hs  = bus.req_valid & bus.req_ready;
        for (int k = 0; k < NR; k++) if (hs[k]) grants.push_back(k);
        if (bus.wb_valid && bus.wb_ready) pop_tags.push_back(int'(bus.wb_tag));
        @(posedge clk);
        #1;
        for (int k = 0; k < NR; k++) if (hs[k]) cnt[k]++;
        drive_reqs();
        bus.alu_wb_valid     = iss | inject;
        bus.alu_wb_rd        = rd;
        bus.alu_wb_is_scalar = dis;
        bus.alu_wb_data      = d;
        bus.alu_wb_err_ovf   = f6[5];
        bus.alu_wb_err_inv   = f6[4];
        inject = 1'b0;
        #1;
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Reference model: compare this cycle's outputs, then apply the coming clock edge.
    always @(negedge clk) begin
        bit iss, out_v;
        int g;
        ent_t e;
        iss = 0;
        g = 0;
        if (rst_n && bus.alu_ready && (m_fifo.size() + m_pipe.size()) < FD)
            for (int i = 0; i < NR; i++)
                if (!iss && bus.req_valid[(m_rr + i) % NR]) begin
                    iss = 1;
                    g = (m_rr + i) % NR;
                end
        if (chk_en) begin
            check("req_ready", DW'(bus.req_ready), iss ? DW'(1 << g) : '0);
            check("alu_valid", DW'(bus.alu_valid), DW'(iss));
            check("alu_op", DW'({bus.alu_funct6, bus.alu_funct3, bus.alu_rd, bus.alu_dest_is_scalar,
                                 bus.alu_scalar_mask}), iss ? DW'(op_word(g)) : '0);
            check("alu_src_a", bus.alu_src_a, iss ? src_a_of(g) : '0);
            check("alu_src_b", bus.alu_src_b, iss ? src_b_of(g) : '0);
            check("wb_valid", DW'(bus.wb_valid), DW'(m_fifo.size() != 0));
            if (m_fifo.size() != 0) begin
                check("wb_meta", DW'({bus.wb_tag, bus.wb_rd, bus.wb_is_scalar, bus.wb_err}),
                      DW'({2'(m_fifo[0].tag), m_fifo[0].rd, m_fifo[0].is_s, m_fifo[0].err}));
                check("wb_data", bus.wb_data, m_fifo[0].data);
            end
            check("err_sticky", DW'(bus.err_sticky), DW'(m_sticky));
            check("proto_err", DW'(bus.proto_err), DW'(m_proto));
        end
        if (!rst_n) begin
            m_fifo.delete();
            m_pipe.delete();
            m_rr = 0;
            m_sticky = '0;
            m_proto = 1'b0;
        end else begin
            out_v = m_pipe.size() != 0 && m_pipe[0].due == cyc;
            if (m_fifo.size() != 0 && bus.wb_ready) void'(m_fifo.pop_front());
            for (int k = 0; k < NR; k++) if (bus.err_clr[k]) m_sticky[2*k +: 2] = 2'b00;
            if (out_v && bus.alu_wb_valid) begin
                e.tag  = m_pipe[0].tag;
                e.rd   = bus.alu_wb_rd;
                e.is_s = bus.alu_wb_is_scalar;
                e.err  = {bus.alu_wb_err_ovf, bus.alu_wb_err_inv};
                e.data = bus.alu_wb_data;
                m_fifo.push_back(e);
                m_sticky[2*e.tag +: 2] = m_sticky[2*e.tag +: 2] | e.err;
            end else if (out_v || bus.alu_wb_valid) m_proto = 1'b1;
            if (out_v) void'(m_pipe.pop_front());
            if (iss) begin
                m_pipe.push_back('{g, cyc + LAT});
                m_rr = (g + 1) % NR;
            end
        end
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < NR; k++) begin
            cnt[k] = 0;
            req_err[k] = 2'b00;
        end
        bus.req_valid = '1;
        bus.alu_ready = 1'b1;
        bus.wb_ready = 1'b0;
        bus.err_clr = '0;
        bus.alu_wb_valid = 1'b0;
        bus.alu_wb_rd = '0;
        bus.alu_wb_is_scalar = 1'b0;
        bus.alu_wb_data = '0;
        bus.alu_wb_err_ovf = 1'b0;
        bus.alu_wb_err_inv = 1'b0;
        drive_reqs();
        ticks(2);
        chk_en = 1;
        // reset state with every requester asserting
        check("rst_req_ready", DW'(bus.req_ready), '0);
        check("rst_alu_valid", DW'(bus.alu_valid), '0);
        check("rst_alu_rd", DW'(bus.alu_rd), '0);
        check("rst_wb_valid", DW'(bus.wb_valid), '0);
        check("rst_sticky", DW'(bus.err_sticky), '0);
        check("rst_proto", DW'(bus.proto_err), '0);
        // all valid, wb_ready=1: round-robin one per cycle
        rst_n = 1'b1;
        bus.wb_ready = 1'b1;
        grants.delete();
        pop_tags.delete();
        #1;
        ticks(10);
        check("t1_issues", DW'(grants.size()), DW'(10));
        for (int i = 0; i < 8; i++) check("t1_grant", DW'(grants[i]), DW'(i % 4));
        for (int i = 0; i < 6; i++) check("t1_wb_tag", DW'(pop_tags[i]), DW'(i % 4));
        // only req2 valid; after one grant rr_ptr=3 and req2 is granted again at once
        bus.req_valid = '0;
        ticks(4);
        grants.delete();
        pop_tags.delete();
        bus.req_valid = 4'b0100;
        tick();
        check("t2_early_wb", DW'(bus.wb_valid), '0);
        check("t2_wrap_grant", DW'(bus.req_ready), DW'(4'b0100));
        tick();
        check("t2_wb_valid", DW'(bus.wb_valid), DW'(1));
        check("t2_wb_tag", DW'(bus.wb_tag), DW'(2));
        bus.req_valid = '0;
        ticks(3);
        check("t2_pops", DW'(pop_tags.size()), DW'(2));
        check("t2_pop1", DW'(pop_tags[1]), DW'(2));
        // wb_ready=0: exactly FIFO_DEPTH issues, then resume without loss
        bus.wb_ready = 1'b0;
        bus.req_valid = '1;
        grants.delete();
        pop_tags.delete();
        ticks(8);
        check("t3_issued", DW'(grants.size()), DW'(FD));
        check("t3_first", DW'(grants[0]), DW'(3));
        check("t3_stalled", DW'(bus.req_ready), '0);
        bus.wb_ready = 1'b1;
        ticks(6);
        bus.req_valid = '0;
        ticks(8);
        check("t3_no_loss", DW'(pop_tags.size()), DW'(grants.size()));
        check("t3_order", DW'(pop_tags[0]), DW'(3));
        // sticky ovf for req1; a same-cycle clear loses to a new set
        req_err[1] = 2'b10;
        drive_reqs();
        bus.req_valid = 4'b0010;
        tick();
        bus.req_valid = '0;
        ticks(2);
        check("t4_set", DW'(bus.err_sticky), DW'(8'b0000_1000));
        bus.req_valid = 4'b0010;
        tick();
        bus.req_valid = '0;
        bus.err_clr = 4'b0010;
        tick();
        bus.err_clr = '0;
        check("t4_set_wins", DW'(bus.err_sticky), DW'(8'b0000_1000));
        bus.err_clr = 4'b0010;
        tick();
        bus.err_clr = '0;
        check("t4_clear", DW'(bus.err_sticky), '0);
        req_err[1] = 2'b00;
        drive_reqs();
        // stray ALU result with nothing in flight
        ticks(3);
        inject = 1'b1;
        ticks(2);
        check("t5_proto", DW'(bus.proto_err), DW'(1));
        check("t5_no_push", DW'(bus.wb_valid), '0);
        ticks(3);
        check("t5_proto_held", DW'(bus.proto_err), DW'(1));
        // reset with ops in flight and entries in the FIFO
        for (int k = 0; k < NR; k++) req_err[k] = 2'b01;
        drive_reqs();
        bus.wb_ready = 1'b0;
        bus.req_valid = '1;
        ticks(4);
        check("t6_pre_wb", DW'(bus.wb_valid), DW'(1));
        check("t6_pre_err", DW'(|bus.err_sticky), DW'(1));
        rst_n = 1'b0;
        tick();
        check("t6_wb_valid", DW'(bus.wb_valid), '0);
        check("t6_sticky", DW'(bus.err_sticky), '0);
        check("t6_proto", DW'(bus.proto_err), '0);
        rst_n = 1'b1;
        #1;
        check("t6_rr_zero", DW'(bus.req_ready), DW'(4'b0001));
        for (int k = 0; k < NR; k++) req_err[k] = 2'b00;
        drive_reqs();
        bus.wb_ready = 1'b1;
        // randomised traffic against the model
        for (int i = 0; i < 300; i++) begin
            bus.req_valid = NR'($urandom);
            bus.wb_ready = ($urandom % 4) != 0;
            bus.alu_ready = ($urandom % 5) != 0;
            bus.err_clr = ($urandom % 6) == 0 ? NR'($urandom) : '0;
            for (int k = 0; k < NR; k++) req_err[k] = ($urandom % 3) == 0 ? 2'($urandom) : 2'b00;
            drive_reqs();
            tick();
        end
        bus.req_valid = '0;
        bus.err_clr = '0;
        bus.wb_ready = 1'b1;
        bus.alu_ready = 1'b1;
        ticks(10);
        check("drained", DW'(bus.wb_valid), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
